tb_run_ctrl: RTL and testbench



---
 rtl/tb_run_ctrl.sv | 175 +++++++++++++++++
 tb/tb_tb_run_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_run_ctrl.sv
// tb_run_ctrl: sequences DUT reset, supervises halt/error/commit channels
// and latches a single end-of-run verdict for the CPU testbench top.
module tb_run_ctrl #(
  parameter int NUM_CH       = 1,
  parameter int CNT_W        = 32,
  parameter int RST_CYCLES   = 2,
  parameter int TIMEOUT      = 10000000,
  parameter int STALL_LIMIT  = 100000,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_CH-1:0]                          halt,
  input  logic [NUM_CH-1:0]                          error,
  input  logic [NUM_CH-1:0]                          commit,
  output logic                                       dut_rst,
  output logic                                       running,
  output logic                                       done,
  output logic                                       pass,
  output logic [1:0]                                 fail_code,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch,
  output logic [NUM_CH-1:0]                          halted_mask,
  output logic [CNT_W-1:0]                           cycle_cnt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST    = TO_VAL - ONE;
  localparam logic [CNT_W-1:0] STALL_VAL  = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] STALL_LAST = STALL_VAL - ONE;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [NUM_CH-1:0] halted_q, halted_d;
  logic [1:0]        fail_code_q, fail_code_d;
  logic [CH_W-1:0]   fail_ch_q, fail_ch_d;
  logic              dut_rst_q, dut_rst_d;

  logic [NUM_CH-1:0] seen;
  logic              any_err;
  logic              all_halt;
  logic              new_halt;
  logic              any_commit;
  logic              hit_to;
  logic              hit_stall;
  logic [CH_W-1:0]   err_idx;

  // Scan high to low so the lowest erroring channel wins.
  always_comb begin
    err_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (error[i]) err_idx = CH_W'(i);
    end
  end

  assign seen       = halted_q | halt;
  assign any_err    = |error;
  assign all_halt   = &seen;
  assign new_halt   = |(halt & ~halted_q);
  assign any_commit = |commit;

  assign hit_to = (TO_VAL != '0) &&
                  (cycle_cnt_q == TO_LAST);

  assign hit_stall = (STALL_VAL != '0) &&
                     !any_commit && !new_halt &&
                     (stall_cnt_q == STALL_LAST);

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    halted_d    = halted_q;
    fail_code_d = fail_code_q;
    fail_ch_d   = fail_ch_q;
    dut_rst_d   = dut_rst_q;
    unique case (state_q)
      S_RESET: begin
        rst_cnt_d = rst_cnt_q + ONE;
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_RUN;
          dut_rst_d = 1'b0;
        end
      end
      S_RUN: begin
        halted_d = seen;
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + ONE;
        end
        if (any_commit || new_halt) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q != '1) begin
          stall_cnt_d = stall_cnt_q + ONE;
        end
        if (any_err) begin
          fail_code_d = 2'd1;
          fail_ch_d   = err_idx;
          state_d     = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else if (all_halt) begin
          state_d = S_DONE;
        end else if (hit_to) begin
          fail_code_d = 2'd2;
          state_d     = S_DONE;
        end else if (hit_stall) begin
          fail_code_d = 2'd3;
          state_d     = S_DONE;
        end
      end
      S_DRAIN: begin
        // Verdict is already latched; late errors only wait out the window.
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + ONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      rst_cnt_q   <= '0;
      stall_cnt_q <= '0;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
      halted_q    <= '0;
      fail_code_q <= 2'd0;
      fail_ch_q   <= '0;
      dut_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      halted_q    <= halted_d;
      fail_code_q <= fail_code_d;
      fail_ch_q   <= fail_ch_d;
      dut_rst_q   <= dut_rst_d;
    end
  end

  assign dut_rst     = dut_rst_q;
  assign running     = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign pass        = done && (fail_code_q == 2'd0);
  assign fail_code   = fail_code_q;
  assign fail_ch     = fail_ch_q;
  assign halted_mask = halted_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Bench for tb_run_ctrl: a 4-channel instance with drain, timeout and stall,
// and a 1-channel instance with no drain/timeout/stall and an 8-bit counter.
module tb_tb_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic        rst_a = 1'b1;
  logic [3:0]  halt_a = '0;
  logic [3:0]  error_a = '0;
  logic [3:0]  commit_a = '0;
  logic        dut_rst_a, running_a, done_a, pass_a;
  logic [1:0]  fail_code_a, fail_ch_a;
  logic [3:0]  halted_mask_a;
  logic [15:0] cycle_cnt_a;

  logic        rst_b = 1'b1;
  logic [0:0]  halt_b = '0;
  logic [0:0]  error_b = '0;
  logic [0:0]  commit_b = '0;
  logic        dut_rst_b, running_b, done_b, pass_b;
  logic [1:0]  fail_code_b;
  logic [0:0]  fail_ch_b;
  logic [0:0]  halted_mask_b;
  logic [7:0]  cycle_cnt_b;

  tb_run_ctrl #(
    .NUM_CH(4), .CNT_W(16), .RST_CYCLES(2),
    .TIMEOUT(50), .STALL_LIMIT(8), .DRAIN_CYCLES(2)
  ) u_a (
    .clk(clk), .rst(rst_a),
    .halt(halt_a), .error(error_a), .commit(commit_a),
    .dut_rst(dut_rst_a), .running(running_a),
    .done(done_a), .pass(pass_a),
    .fail_code(fail_code_a), .fail_ch(fail_ch_a),
    .halted_mask(halted_mask_a), .cycle_cnt(cycle_cnt_a)
  );

  tb_run_ctrl #(
    .NUM_CH(1), .CNT_W(8), .RST_CYCLES(3),
    .TIMEOUT(0), .STALL_LIMIT(0), .DRAIN_CYCLES(0)
  ) u_b (
    .clk(clk), .rst(rst_b),
    .halt(halt_b), .error(error_b), .commit(commit_b),
    .dut_rst(dut_rst_b), .running(running_b),
    .done(done_b), .pass(pass_b),
    .fail_code(fail_code_b), .fail_ch(fail_ch_b),
    .halted_mask(halted_mask_b), .cycle_cnt(cycle_cnt_b)
  );

  typedef struct {
    string       name;
    bit          is_b;
    logic        pass;
    logic [1:0]  code;
    logic [1:0]  ch;
    logic [3:0]  mask;
    logic [15:0] cyc;
    int          lat;
  } verdict_t;

  verdict_t sb_q[$];

  task automatic push_exp(input string name, input bit is_b,
                          input logic p, input logic [1:0] code,
                          input logic [1:0] ch, input logic [3:0] mask,
                          input logic [15:0] cyc, input int lat);
    verdict_t v;
    v.name = name; v.is_b = is_b; v.pass = p; v.code = code;
    v.ch = ch; v.mask = mask; v.cyc = cyc; v.lat = lat;
    sb_q.push_back(v);
  endtask

  // Waits for the verdict of the oldest queued scenario and scores it.
  task automatic sb_wait();
    verdict_t    v;
    int          lat;
    logic        d;
    logic        p;
    logic [1:0]  code, ch;
    logic [3:0]  mask;
    logic [15:0] cyc;
    v = sb_q.pop_front();
    lat = 0;
    d = 1'b0;
    while (!d && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (v.is_b) begin halt_b = '0; error_b = '0; end
        else begin halt_a = '0; error_a = '0; end
      end
      d = v.is_b ? done_b : done_a;
    end
    p    = v.is_b ? pass_b : pass_a;
    code = v.is_b ? fail_code_b : fail_code_a;
    ch   = v.is_b ? {1'b0, fail_ch_b} : fail_ch_a;
    mask = v.is_b ? {3'b0, halted_mask_b} : halted_mask_a;
    cyc  = v.is_b ? {8'h0, cycle_cnt_b} : cycle_cnt_a;
    n_checks++;
    if (d !== 1'b1 || lat != v.lat)
      $display("FAIL %s.latency got done=%b after %0d want %0d", v.name, d, lat, v.lat);
    else n_pass++;
    n_checks++;
    if (p !== v.pass)
      $display("FAIL %s.pass got %b want %b", v.name, p, v.pass);
    else n_pass++;
    n_checks++;
    if (code !== v.code)
      $display("FAIL %s.fail_code got %0d want %0d", v.name, code, v.code);
    else n_pass++;
    n_checks++;
    if (ch !== v.ch)
      $display("FAIL %s.fail_ch got %0d want %0d", v.name, ch, v.ch);
    else n_pass++;
    n_checks++;
    if (mask !== v.mask)
      $display("FAIL %s.halted_mask got %b want %b", v.name, mask, v.mask);
    else n_pass++;
    n_checks++;
    if (cyc !== v.cyc)
      $display("FAIL %s.cycle_cnt got %0d want %0d", v.name, cyc, v.cyc);
    else n_pass++;
  endtask

  task automatic start_a();
    rst_a = 1'b1; halt_a = '0; error_a = '0; commit_a = '0;
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 10 && running_a !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (running_a !== 1'b1) $display("FAIL start_a.running got %b want 1", running_a);
    else n_pass++;
  endtask

  task automatic start_b();
    rst_b = 1'b1; halt_b = '0; error_b = '0; commit_b = '0;
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 10 && running_b !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (running_b !== 1'b1) $display("FAIL start_b.running got %b want 1", running_b);
    else n_pass++;
  endtask

  task automatic test_reset_a();
    logic [27:0] got;
    rst_a = 1'b1;
    @(negedge clk);
    got = {dut_rst_a, running_a, done_a, pass_a, fail_code_a,
           fail_ch_a, halted_mask_a, cycle_cnt_a};
    n_checks++;
    if (got !== {4'b1000, 2'd0, 2'd0, 4'd0, 16'd0})
      $display("FAIL reset_a.outputs got %h want %h", got, {4'b1000, 24'd0});
    else n_pass++;
    rst_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dut_rst_a, running_a} !== 2'b10)
      $display("FAIL reset_a.hold got %b want 10", {dut_rst_a, running_a});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({dut_rst_a, running_a} !== 2'b01)
      $display("FAIL reset_a.release got %b want 01", {dut_rst_a, running_a});
    else n_pass++;
  endtask

  task automatic test_halt_order();
    start_a();
    halt_a = 4'b0100; @(negedge clk);
    halt_a = 4'b0001; @(negedge clk);
    halt_a = 4'b1000; @(negedge clk);
    n_checks++;
    if ({done_a, halted_mask_a} !== 5'b0_1101)
      $display("FAIL halt_order.partial got %b want 01101", {done_a, halted_mask_a});
    else n_pass++;
    halt_a = 4'b0010;
    push_exp("halt_order", 1'b0, 1'b1, 2'd0, 2'd0, 4'hf, 16'd4, 1);
    sb_wait();
  endtask

  task automatic test_error_drain();
    start_a();
    for (int i = 0; i < 3; i++) begin commit_a = 4'b0001; @(negedge clk); end
    commit_a = '0;
    error_a = 4'b1010;
    @(negedge clk);
    n_checks++;
    if ({done_a, fail_code_a, fail_ch_a} !== 5'b0_01_01)
      $display("FAIL error_drain.early got %b want 00101", {done_a, fail_code_a, fail_ch_a});
    else n_pass++;
    error_a = 4'b0001;
    push_exp("error_drain", 1'b0, 1'b0, 2'd1, 2'd1, 4'h0, 16'd4, 2);
    sb_wait();
  endtask

  task automatic test_stall();
    start_a();
    for (int i = 0; i < 5; i++) begin commit_a = 4'b0100; @(negedge clk); end
    commit_a = '0;
    push_exp("stall", 1'b0, 1'b0, 2'd3, 2'd0, 4'h0, 16'd13, 8);
    sb_wait();
  endtask

  task automatic test_stall_halt();
    start_a();
    for (int i = 0; i < 5; i++) begin commit_a = 4'b1000; @(negedge clk); end
    commit_a = '0;
    repeat (5) @(negedge clk);
    halt_a = 4'b0001;
    @(negedge clk);
    halt_a = '0;
    push_exp("stall_halt", 1'b0, 1'b0, 2'd3, 2'd0, 4'h1, 16'd19, 8);
    sb_wait();
  endtask

  task automatic test_timeout();
    start_a();
    commit_a = 4'b0001;
    push_exp("timeout", 1'b0, 1'b0, 2'd2, 2'd0, 4'h0, 16'd50, 50);
    sb_wait();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done_a, cycle_cnt_a} !== {1'b1, 16'd50})
      $display("FAIL timeout.freeze got done=%b cyc=%0d want 1/50", done_a, cycle_cnt_a);
    else n_pass++;
    commit_a = '0;
  endtask

  task automatic test_simul();
    start_a();
    halt_a = 4'b1111;
    error_a = 4'b0100;
    push_exp("simul", 1'b0, 1'b0, 2'd1, 2'd2, 4'hf, 16'd1, 3);
    sb_wait();
  endtask

  task automatic test_rst_mid();
    logic [27:0] got;
    start_a();
    for (int i = 0; i < 3; i++) begin commit_a = 4'b0010; @(negedge clk); end
    commit_a = '0;
    halt_a = 4'b0001;
    rst_a = 1'b1;
    @(negedge clk);
    halt_a = '0;
    got = {dut_rst_a, running_a, done_a, pass_a, fail_code_a,
           fail_ch_a, halted_mask_a, cycle_cnt_a};
    n_checks++;
    if (got !== {4'b1000, 24'd0})
      $display("FAIL rst_run.outputs got %h want %h", got, {4'b1000, 24'd0});
    else n_pass++;
    rst_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dut_rst_a, running_a} !== 2'b10)
      $display("FAIL rst_run.hold got %b want 10", {dut_rst_a, running_a});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({dut_rst_a, running_a, cycle_cnt_a} !== {2'b01, 16'd0})
      $display("FAIL rst_run.release got %b cyc=%0d want 01 cyc=0", {dut_rst_a, running_a}, cycle_cnt_a);
    else n_pass++;
    halt_a = 4'b1111;
    @(negedge clk);
    n_checks++;
    if ({done_a, pass_a} !== 2'b11)
      $display("FAIL rst_done.verdict got %b want 11", {done_a, pass_a});
    else n_pass++;
    rst_a = 1'b1;
    @(negedge clk);
    halt_a = '0;
    got = {dut_rst_a, running_a, done_a, pass_a, fail_code_a,
           fail_ch_a, halted_mask_a, cycle_cnt_a};
    n_checks++;
    if (got !== {4'b1000, 24'd0})
      $display("FAIL rst_done.outputs got %h want %h", got, {4'b1000, 24'd0});
    else n_pass++;
    rst_a = 1'b0;
  endtask

  task automatic test_reset_b();
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({dut_rst_b, running_b} !== 2'b10)
        $display("FAIL reset_b.hold%0d got %b want 10", i, {dut_rst_b, running_b});
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({dut_rst_b, running_b} !== 2'b01)
      $display("FAIL reset_b.release got %b want 01", {dut_rst_b, running_b});
    else n_pass++;
  endtask

  task automatic test_halt_b();
    start_b();
    for (int i = 0; i < 10; i++) begin commit_b = 1'b1; @(negedge clk); end
    commit_b = 1'b0;
    halt_b = 1'b1;
    push_exp("halt_b", 1'b1, 1'b1, 2'd0, 2'd0, 4'h1, 16'd11, 1);
    sb_wait();
  endtask

  task automatic test_error_nodrain();
    start_b();
    repeat (20) @(negedge clk);
    error_b = 1'b1;
    push_exp("error_nodrain", 1'b1, 1'b0, 2'd1, 2'd0, 4'h0, 16'd21, 1);
    sb_wait();
  endtask

  task automatic test_saturate();
    start_b();
    repeat (300) @(negedge clk);
    n_checks++;
    if ({running_b, cycle_cnt_b} !== {1'b1, 8'hff})
      $display("FAIL saturate.cnt got run=%b cyc=%0d want 1/255", running_b, cycle_cnt_b);
    else n_pass++;
    halt_b = 1'b1;
    push_exp("saturate", 1'b1, 1'b1, 2'd0, 2'd0, 4'h1, 16'd255, 1);
    sb_wait();
  endtask

  initial begin
    test_reset_a();
    test_halt_order();
    test_error_drain();
    test_stall();
    test_stall_halt();
    test_timeout();
    test_simul();
    test_rst_mid();
    test_reset_b();
    test_halt_b();
    test_error_nodrain();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
